// File: rtl/board_if.sv
// rtl/board_if.sv - Bundle of the CPU's halt, RAM-load and observation signals.
// Purpose: groups everything except clk/clr so the board and its driver share one port.
// Ports (master = driver side, slave = board side):
//   hlt        external pause
//   prog_we    RAM load strobe
//   prog_addr  RAM load address
//   prog_data  RAM load data
//   out        output register
//   out_stb    one-cycle pulse after an OUT updates out
//   halted     HLT instruction has executed
//   pc         program counter (debug)
//   areg       A register (debug)
interface board_if;
  logic       hlt;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [7:0] out;
  logic       out_stb;
  logic       halted;
  logic [3:0] pc;
  logic [7:0] areg;

  modport master (
    output hlt, prog_we, prog_addr, prog_data,
    input  out, out_stb, halted, pc, areg
  );

  modport slave (
    input  hlt, prog_we, prog_addr, prog_data,
    output out, out_stb, halted, pc, areg
  );
endinterface

// File: rtl/board.sv
// rtl/board.sv - SAP-1-style 8-bit microcoded CPU with 16x8 RAM on a shared bus.
// Purpose: fetch/execute of 4-bit-opcode instructions in five micro-steps T0..T4.
// Ports:
//   clk  system clock, rising edge
//   clr  synchronous active-high reset of CPU state (RAM untouched)
//   io   board_if.slave: hlt, prog_we/prog_addr/prog_data in; out, out_stb, halted, pc, areg out

module board_ram (
  input  logic       clk_i,
  input  logic       we_i,
  input  logic [3:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [3:0] raddr_i,
  output logic [7:0] rdata_o
);
  logic [7:0] mem [0:15];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];
endmodule

module board (
  input  logic    clk,
  input  logic    clr,
  board_if.slave  io
);
  typedef enum logic [2:0] {T0, T1, T2, T3, T4} step_e;
  typedef enum logic [2:0] {SRC_NONE, SRC_PC, SRC_RAM, SRC_IR, SRC_A, SRC_ALU} src_e;

  step_e      step_q, step_d;
  logic [3:0] pc_q, mar_q;
  logic [7:0] ir_q, a_q, b_q, out_q;
  logic       carry_q, zero_q, halt_q, stb_q;

  src_e       src;
  logic       mar_ld, ir_ld, pc_ld, pc_inc, a_ld, b_ld, ram_we, out_ld, hlt_set, flags_ld;
  logic [7:0] bus, ram_rdata;
  logic [8:0] sum;
  logic [3:0] opcode;
  logic       sub, freeze;

  assign opcode = ir_q[7:4];
  assign sub    = (opcode == 4'h3);
  assign freeze = halt_q | io.hlt;

  // Subtraction as A + ~B + 1, so carry=1 means no borrow.
  assign sum = {1'b0, a_q} + {1'b0, (sub ? ~b_q : b_q)} + {8'h00, sub};

  always_comb begin
    step_d   = step_q;
    src      = SRC_NONE;
    mar_ld   = 1'b0;
    ir_ld    = 1'b0;
    pc_ld    = 1'b0;
    pc_inc   = 1'b0;
    a_ld     = 1'b0;
    b_ld     = 1'b0;
    ram_we   = 1'b0;
    out_ld   = 1'b0;
    hlt_set  = 1'b0;
    flags_ld = 1'b0;
    case (step_q)
      T0: begin
        step_d = T1;
        src    = SRC_PC;
        mar_ld = 1'b1;
      end
      T1: begin
        step_d = T2;
        src    = SRC_RAM;
        ir_ld  = 1'b1;
        pc_inc = 1'b1;
      end
      T2: begin
        step_d = T3;
        case (opcode)
          4'h1, 4'h2, 4'h3, 4'h4: begin src = SRC_IR; mar_ld = 1'b1; end
          4'h5: begin src = SRC_IR; a_ld = 1'b1; end
          4'h6: begin src = SRC_IR; pc_ld = 1'b1; end
          4'h7: if (carry_q) begin src = SRC_IR; pc_ld = 1'b1; end
          4'h8: if (zero_q) begin src = SRC_IR; pc_ld = 1'b1; end
          4'hE: begin src = SRC_A; out_ld = 1'b1; end
          4'hF: hlt_set = 1'b1;
          default: ;
        endcase
      end
      T3: begin
        step_d = T4;
        case (opcode)
          4'h1: begin src = SRC_RAM; a_ld = 1'b1; end
          4'h2, 4'h3: begin src = SRC_RAM; b_ld = 1'b1; end
          4'h4: begin src = SRC_A; ram_we = 1'b1; end
          default: ;
        endcase
      end
      T4: begin
        step_d = T0;
        if (opcode == 4'h2 || opcode == 4'h3) begin
          src      = SRC_ALU;
          a_ld     = 1'b1;
          flags_ld = 1'b1;
        end
      end
      default: step_d = T0;
    endcase
  end

  always_comb begin
    bus = 8'h00;
    case (src)
      SRC_PC:  bus = {4'h0, pc_q};
      SRC_RAM: bus = ram_rdata;
      SRC_IR:  bus = {4'h0, ir_q[3:0]};
      SRC_A:   bus = a_q;
      SRC_ALU: bus = sum[7:0];
      default: bus = 8'h00;
    endcase
  end

  // The load port takes the write port over from an STA in the same cycle.
  board_ram rm (
    .clk_i   (clk),
    .we_i    (io.prog_we | (ram_we & ~freeze & ~clr)),
    .waddr_i (io.prog_we ? io.prog_addr : mar_q),
    .wdata_i (io.prog_we ? io.prog_data : bus),
    .raddr_i (mar_q),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      step_q  <= T0;
      pc_q    <= 4'h0;
      mar_q   <= 4'h0;
      ir_q    <= 8'h00;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      out_q   <= 8'h00;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      halt_q  <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      // Strobe is not frozen so a pause right after OUT cannot stretch it.
      stb_q <= out_ld & ~freeze;
      if (!freeze) begin
        step_q <= step_d;
        if (mar_ld) mar_q <= bus[3:0];
        if (ir_ld) ir_q <= bus;
        if (pc_ld) pc_q <= bus[3:0];
        else if (pc_inc) pc_q <= pc_q + 4'h1;
        if (a_ld) a_q <= bus;
        if (b_ld) b_q <= bus;
        if (out_ld) out_q <= bus;
        if (flags_ld) begin
          carry_q <= sum[8];
          zero_q  <= (sum[7:0] == 8'h00);
        end
        if (hlt_set) halt_q <= 1'b1;
      end
    end
  end

  assign io.out     = out_q;
  assign io.out_stb = stb_q;
  assign io.halted  = halt_q;
  assign io.pc      = pc_q;
  assign io.areg    = a_q;
endmodule

// File: tb/tb_board.sv
// tb/tb_board.sv - Self-checking bench for board: program table plus hlt/clr sequences.
module tb_board;
  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  board_if bif ();
  board dut (.clk(clk), .clr(clr), .io(bif));

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];
  logic [7:0] sb_exp;

  typedef struct {
    logic [15:0][7:0] prog;
    logic [3:0][7:0]  outs;
    int               nouts;
    logic [3:0]       pc;
    logic [7:0]       a;
    logic             c;
    logic             z;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: each out_stb pulse pops the next expected output byte.
  always @(negedge clk) begin
    if (bif.out_stb === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_stb_unexpected: got %0h expected none", bif.out);
      end else begin
        sb_exp = exp_q.pop_front();
        chk("out_stb_value", {24'h0, bif.out}, {24'h0, sb_exp});
      end
    end
  end

  task automatic wr(input int v, input int addr, input logic [7:0] d);
    vecs[v].prog[addr] = d;
  endtask

  task automatic set_exp(input int v, input logic [3:0] pc, input logic [7:0] a,
                         input logic c, input logic z);
    vecs[v].pc = pc;
    vecs[v].a  = a;
    vecs[v].c  = c;
    vecs[v].z  = z;
  endtask

  task automatic add_out(input int v, input logic [7:0] d);
    vecs[v].outs[vecs[v].nouts] = d;
    vecs[v].nouts++;
  endtask

  task automatic load_and_clear(input int v);
    clr = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bif.prog_we   = 1'b1;
      bif.prog_addr = 4'(i);
      bif.prog_data = vecs[v].prog[i];
      tick();
    end
    bif.prog_we = 1'b0;
    tick();
    chk("rst_out", {24'h0, bif.out}, 32'h0);
    chk("rst_out_stb", {31'h0, bif.out_stb}, 32'h0);
    chk("rst_halted", {31'h0, bif.halted}, 32'h0);
    chk("rst_pc", {28'h0, bif.pc}, 32'h0);
    chk("rst_areg", {24'h0, bif.areg}, 32'h0);
  endtask

  task automatic run_to_halt(input string name);
    int n = 0;
    while (bif.halted !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk({name, "_halted"}, {31'h0, bif.halted}, 32'h1);
    repeat (6) tick();
  endtask

  initial begin
    bif.hlt       = 1'b0;
    bif.prog_we   = 1'b0;
    bif.prog_addr = 4'h0;
    bif.prog_data = 8'h00;
    for (int v = 0; v < 6; v++) begin
      vecs[v].prog  = '0;
      vecs[v].outs  = '0;
      vecs[v].nouts = 0;
    end

    // 0: LDA E; ADD F; OUT; HLT  -> 38+23
    wr(0, 0, 8'h1E); wr(0, 1, 8'h2F); wr(0, 2, 8'hE0); wr(0, 3, 8'hF0);
    wr(0, 14, 8'h38); wr(0, 15, 8'h23);
    add_out(0, 8'h5B); set_exp(0, 4'h4, 8'h5B, 1'b0, 1'b0);
    // 1: SUB with borrow 05-07
    wr(1, 0, 8'h1E); wr(1, 1, 8'h3F); wr(1, 2, 8'hE0); wr(1, 3, 8'hF0);
    wr(1, 14, 8'h05); wr(1, 15, 8'h07);
    add_out(1, 8'hFE); set_exp(1, 4'h4, 8'hFE, 1'b0, 1'b0);
    // 2: LDI 3; loop { OUT; SUB 1; JZ 6; JMP 1 }; 6: OUT; HLT
    wr(2, 0, 8'h53); wr(2, 1, 8'hE0); wr(2, 2, 8'h3F); wr(2, 3, 8'h86);
    wr(2, 4, 8'h61); wr(2, 5, 8'hF0); wr(2, 6, 8'hE0); wr(2, 7, 8'hF0);
    wr(2, 15, 8'h01);
    add_out(2, 8'h03); add_out(2, 8'h02); add_out(2, 8'h01); add_out(2, 8'h00);
    set_exp(2, 4'h8, 8'h00, 1'b1, 1'b1);
    // 3: FF+01 then JC 8; 8: OUT; HLT
    wr(3, 0, 8'h1E); wr(3, 1, 8'h2F); wr(3, 2, 8'h78); wr(3, 3, 8'h5F);
    wr(3, 4, 8'hE0); wr(3, 5, 8'hF0); wr(3, 8, 8'hE0); wr(3, 9, 8'hF0);
    wr(3, 14, 8'hFF); wr(3, 15, 8'h01);
    add_out(3, 8'h00); set_exp(3, 4'hA, 8'h00, 1'b1, 1'b1);
    // 4: PC wrap 15->0, JC not taken then taken, opcode 9 as NOP
    wr(4, 0, 8'h2C); wr(4, 1, 8'hE0); wr(4, 2, 8'h75); wr(4, 3, 8'h6D);
    wr(4, 5, 8'hF0); wr(4, 12, 8'h80); wr(4, 13, 8'h9F);
    add_out(4, 8'h80); add_out(4, 8'h00); set_exp(4, 4'h6, 8'h00, 1'b1, 1'b1);
    // 5: LDA E; STA D; ADD D; OUT; HLT
    wr(5, 0, 8'h1E); wr(5, 1, 8'h4D); wr(5, 2, 8'h2D); wr(5, 3, 8'hE0);
    wr(5, 4, 8'hF0); wr(5, 14, 8'h07);
    add_out(5, 8'h0E); set_exp(5, 4'h5, 8'h0E, 1'b0, 1'b0);

    for (int v = 0; v < 6; v++) begin
      load_and_clear(v);
      for (int k = 0; k < vecs[v].nouts; k++) exp_q.push_back(vecs[v].outs[k]);
      clr = 1'b0;
      run_to_halt($sformatf("v%0d", v));
      chk($sformatf("v%0d_pc", v), {28'h0, bif.pc}, {28'h0, vecs[v].pc});
      chk($sformatf("v%0d_areg", v), {24'h0, bif.areg}, {24'h0, vecs[v].a});
      chk($sformatf("v%0d_out", v), {24'h0, bif.out}, {24'h0, vecs[v].outs[vecs[v].nouts-1]});
      chk($sformatf("v%0d_carry", v), {31'h0, dut.carry_q}, {31'h0, vecs[v].c});
      chk($sformatf("v%0d_zero", v), {31'h0, dut.zero_q}, {31'h0, vecs[v].z});
      chk($sformatf("v%0d_sb_drained", v), exp_q.size(), 0);
    end

    // Exact timing of the first program: out after edge 13, halted after edge 18.
    load_and_clear(0);
    exp_q.push_back(8'h5B);
    clr = 1'b0;
    repeat (12) tick();
    chk("t_out_edge12", {24'h0, bif.out}, 32'h0);
    tick();
    chk("t_out_edge13", {24'h0, bif.out}, 32'h5B);
    chk("t_stb_edge13", {31'h0, bif.out_stb}, 32'h1);
    tick();
    chk("t_stb_edge14", {31'h0, bif.out_stb}, 32'h0);
    repeat (3) tick();
    chk("t_halted_edge17", {31'h0, bif.halted}, 32'h0);
    tick();
    chk("t_halted_edge18", {31'h0, bif.halted}, 32'h1);
    repeat (8) tick();
    chk("t_pc_frozen", {28'h0, bif.pc}, 32'h4);
    chk("t_out_frozen", {24'h0, bif.out}, 32'h5B);

    // External hlt for 10 cycles after edge 7 (ADD fetched, A=38, PC=2).
    load_and_clear(0);
    exp_q.push_back(8'h5B);
    clr = 1'b0;
    repeat (7) tick();
    bif.hlt = 1'b1;
    repeat (10) tick();
    chk("hlt_pc", {28'h0, bif.pc}, 32'h2);
    chk("hlt_areg", {24'h0, bif.areg}, 32'h38);
    chk("hlt_not_halted", {31'h0, bif.halted}, 32'h0);
    bif.hlt = 1'b0;
    run_to_halt("hlt_resume");
    chk("hlt_resume_out", {24'h0, bif.out}, 32'h5B);
    chk("hlt_resume_pc", {28'h0, bif.pc}, 32'h4);

    // clr on the ADD T3 edge (edge 9) aborts; rerun from address 0.
    load_and_clear(0);
    clr = 1'b0;
    repeat (8) tick();
    clr = 1'b1;
    tick();
    chk("abort_out", {24'h0, bif.out}, 32'h0);
    chk("abort_pc", {28'h0, bif.pc}, 32'h0);
    chk("abort_areg", {24'h0, bif.areg}, 32'h0);
    chk("abort_halted", {31'h0, bif.halted}, 32'h0);
    chk("abort_stb", {31'h0, bif.out_stb}, 32'h0);
    exp_q.push_back(8'h5B);
    clr = 1'b0;
    run_to_halt("abort_rerun");
    chk("abort_rerun_out", {24'h0, bif.out}, 32'h5B);
    chk("abort_rerun_areg", {24'h0, bif.areg}, 32'h5B);
    chk("final_sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
